uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl_if.sv | 20 ++
 rtl/uart_rx_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Receive-side byte handshake between uart_rx_ctrl (master) and its consumer (slave).
interface uart_rx_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       parity_err;
   logic       frame_err;
   logic       overrun_err;
   logic       err_clr;

   modport master (
      output rx_data, rx_valid, parity_err, frame_err, overrun_err,
      input  rx_ready, err_clr
   );

   modport slave (
      input  rx_data, rx_valid, parity_err, frame_err, overrun_err,
      output rx_ready, err_clr
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Oversampled 8-bit UART receiver: start, 8 data (LSB first), parity, stop.
// Frames are delivered over a valid/ready handshake with sticky overrun detection.
module uart_rx_ctrl #(
   parameter int OVERSAMPLE = 16,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic           baud_clk,
   input  logic           reset,
   input  logic           data_tx,
   output logic           shift_en,
   output logic           shift_bit,
   output logic           active_flag,
   uart_rx_ctrl_if.master rx_if
);

   localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] SAMPLE_TICK = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] LAST_TICK   = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic            armed_q, armed_d;
   logic            rxs_meta_q, rxs_meta_d;
   logic            rxs_q, rxs_d;
   logic [7:0]      byte_q, byte_d;
   logic            par_q, par_d;
   logic            shift_en_q, shift_en_d;
   logic            shift_bit_q, shift_bit_d;
   logic            active_flag_q, active_flag_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            parity_err_q, parity_err_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_err_q, overrun_err_d;

   logic            is_sample;
   logic            is_last;
   logic            complete;
   logic            overrun_set;

   always_comb begin
      state_d       = state_q;
      cnt_d         = is_last ? '0 : cnt_q + 1'b1;
      bit_idx_d     = bit_idx_q;
      armed_d       = armed_q;
      rxs_meta_d    = data_tx;
      rxs_d         = rxs_meta_q;
      byte_d        = byte_q;
      par_d         = par_q;
      shift_en_d    = 1'b0;
      shift_bit_d   = shift_bit_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q;
      parity_err_d  = parity_err_q;
      frame_err_d   = frame_err_q;
      overrun_err_d = overrun_err_q;
      complete      = 1'b0;
      overrun_set   = 1'b0;
      is_sample     = (cnt_q == SAMPLE_TICK);
      is_last       = (cnt_q == LAST_TICK);

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (rxs_q) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (is_sample && rxs_q) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (is_last) begin
               state_d   = S_DATA;
               bit_idx_d = '0;
               cnt_d     = '0;
            end
         end
         S_DATA: begin
            if (is_sample) begin
               shift_en_d  = 1'b1;
               shift_bit_d = rxs_q;
               byte_d      = {rxs_q, byte_q[7:1]};
            end
            if (is_last) begin
               cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_PARITY;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (is_sample) begin
               shift_en_d  = 1'b1;
               shift_bit_d = rxs_q;
               par_d       = rxs_q;
            end
            if (is_last) begin
               state_d = S_STOP;
               cnt_d   = '0;
            end
         end
         S_STOP: begin
            // Leave at mid-stop so a start bit right after the stop bit is not missed.
            if (is_sample) begin
               shift_en_d  = 1'b1;
               shift_bit_d = rxs_q;
               complete    = 1'b1;
               state_d     = S_IDLE;
               cnt_d       = '0;
               if (!rxs_q) begin
                  armed_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (complete && (!rx_valid_q || rx_if.rx_ready)) begin
         rx_data_d    = byte_q;
         parity_err_d = ^{byte_q, par_q, PARITY_ODD};
         frame_err_d  = ~rxs_q;
         rx_valid_d   = 1'b1;
      end else if (complete) begin
         overrun_set = 1'b1;
      end else if (rx_valid_q && rx_if.rx_ready) begin
         rx_valid_d = 1'b0;
      end

      if (overrun_set) begin
         overrun_err_d = 1'b1;
      end else if (rx_if.err_clr) begin
         overrun_err_d = 1'b0;
      end

      active_flag_d = (state_d != S_IDLE);
   end

   always_ff @(posedge baud_clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         armed_q       <= 1'b0;
         rxs_meta_q    <= 1'b1;
         rxs_q         <= 1'b1;
         byte_q        <= '0;
         par_q         <= 1'b0;
         shift_en_q    <= 1'b0;
         shift_bit_q   <= 1'b0;
         active_flag_q <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         parity_err_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         armed_q       <= armed_d;
         rxs_meta_q    <= rxs_meta_d;
         rxs_q         <= rxs_d;
         byte_q        <= byte_d;
         par_q         <= par_d;
         shift_en_q    <= shift_en_d;
         shift_bit_q   <= shift_bit_d;
         active_flag_q <= active_flag_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         parity_err_q  <= parity_err_d;
         frame_err_q   <= frame_err_d;
         overrun_err_q <= overrun_err_d;
      end
   end

   assign shift_en          = shift_en_q;
   assign shift_bit         = shift_bit_q;
   assign active_flag       = active_flag_q;
   assign rx_if.rx_data     = rx_data_q;
   assign rx_if.rx_valid    = rx_valid_q;
   assign rx_if.parity_err  = parity_err_q;
   assign rx_if.frame_err   = frame_err_q;
   assign rx_if.overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: serial frames in, scoreboard of expected bytes/flags out.
module tb_uart_rx_ctrl;
   localparam int OS  = 16;
   localparam bit ODD = 1'b0;
   // Frame latency from first rxs==0 cycle, plus two synchronizer stages from data_tx.
   localparam int LAT = 1 + OS * 10 + OS / 2 + 2;

   logic baud_clk = 1'b0;
   logic reset;
   logic data_tx;
   logic shift_en;
   logic shift_bit;
   logic active_flag;

   uart_rx_ctrl_if rif ();

   uart_rx_ctrl #(.OVERSAMPLE(OS), .PARITY_ODD(ODD)) dut (
      .baud_clk    (baud_clk),
      .reset       (reset),
      .data_tx     (data_tx),
      .shift_en    (shift_en),
      .shift_bit   (shift_bit),
      .active_flag (active_flag),
      .rx_if       (rif.master)
   );

   always #5 baud_clk = ~baud_clk;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   int         cyc = 0;
   int         rise_total = 0;
   int         shift_total = 0;
   int         active_total = 0;
   int         rise_cyc = 0;
   logic       prev_valid = 1'b0;
   logic [7:0] cap_data = '0;
   logic       cap_perr = 1'b0;
   logic       cap_ferr = 1'b0;
   logic [9:0] cap_shift = '0;

   always @(posedge baud_clk) cyc <= cyc + 1;

   always @(negedge baud_clk) begin
      prev_valid <= rif.rx_valid;
      if (rif.rx_valid && !prev_valid) begin
         rise_total <= rise_total + 1;
         rise_cyc   <= cyc;
         cap_data   <= rif.rx_data;
         cap_perr   <= rif.parity_err;
         cap_ferr   <= rif.frame_err;
      end
      if (shift_en) begin
         shift_total <= shift_total + 1;
         cap_shift   <= {shift_bit, cap_shift[9:1]};
      end
      if (active_flag) active_total <= active_total + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      data_tx = b;
      repeat (OS) @(negedge baud_clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(par);
      drive_bit(stp);
   endtask

   task automatic push(input logic [7:0] d, input logic par, input logic stp);
      exp_t e;
      e.data = d;
      e.perr = (^d) ^ par ^ ODD;
      e.ferr = ~stp;
      sb.push_back(e);
   endtask

   task automatic expect_frame(input string tag, input int snap);
      exp_t e;
      int   n;
      n = 0;
      while (rise_total == snap && n < 400) begin
         @(negedge baud_clk);
         n++;
      end
      chk({tag, "_valid_rise"}, 32'(rise_total - snap), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_data"}, 32'(cap_data), 32'(e.data));
         chk({tag, "_perr"}, 32'(cap_perr), 32'(e.perr));
         chk({tag, "_ferr"}, 32'(cap_ferr), 32'(e.ferr));
      end
   endtask

   task automatic consume(input string tag);
      rif.rx_ready = 1'b1;
      @(negedge baud_clk);
      rif.rx_ready = 1'b0;
      chk({tag, "_valid_cleared"}, 32'(rif.rx_valid), 32'd0);
   endtask

   initial begin
      int snap;
      int snap_sh;
      int snap_act;
      int t0;
      logic pbit;

      reset        = 1'b1;
      data_tx      = 1'b1;
      rif.rx_ready = 1'b0;
      rif.err_clr  = 1'b0;
      repeat (3) @(negedge baud_clk);
      chk("rst_shift_en", 32'(shift_en), 32'd0);
      chk("rst_shift_bit", 32'(shift_bit), 32'd0);
      chk("rst_active", 32'(active_flag), 32'd0);
      chk("rst_valid", 32'(rif.rx_valid), 32'd0);
      chk("rst_data", 32'(rif.rx_data), 32'd0);
      chk("rst_perr", 32'(rif.parity_err), 32'd0);
      chk("rst_ferr", 32'(rif.frame_err), 32'd0);
      chk("rst_ovr", 32'(rif.overrun_err), 32'd0);
      reset = 1'b0;
      repeat (5) @(negedge baud_clk);

      // 0x55, correct even parity, good stop: latency and shift pulses
      snap = rise_total; snap_sh = shift_total; t0 = cyc;
      push(8'h55, 1'b0, 1'b1);
      send_frame(8'h55, 1'b0, 1'b1);
      expect_frame("f55", snap);
      chk("f55_latency", 32'(rise_cyc - t0), 32'(LAT));
      chk("f55_shift_cnt", 32'(shift_total - snap_sh), 32'd10);
      chk("f55_shift_bits", 32'(cap_shift), 32'({1'b1, 1'b0, 8'h55}));
      chk("f55_valid_held", 32'(rif.rx_valid), 32'd1);
      consume("f55");

      // false start: 4 cycles low
      snap = rise_total; snap_sh = shift_total; snap_act = active_total;
      data_tx = 1'b0;
      repeat (4) @(negedge baud_clk);
      data_tx = 1'b1;
      repeat (30) @(negedge baud_clk);
      chk("fs_active_1to9", 32'((active_total - snap_act) >= 1 && (active_total - snap_act) <= 9), 32'd1);
      chk("fs_no_shift", 32'(shift_total - snap_sh), 32'd0);
      chk("fs_no_valid", 32'(rise_total - snap), 32'd0);

      // 0xA3 with wrong parity bit
      snap = rise_total;
      push(8'hA3, 1'b1, 1'b1);
      send_frame(8'hA3, 1'b1, 1'b1);
      expect_frame("fA3", snap);
      consume("fA3");

      // 0x0F with stop low, line held low afterwards: no re-arm until high
      snap = rise_total;
      pbit = (^8'h0F) ^ ODD;
      push(8'h0F, pbit, 1'b0);
      send_frame(8'h0F, pbit, 1'b0);
      expect_frame("f0F", snap);
      consume("f0F");
      snap_act = active_total; snap = rise_total;
      repeat (48) @(negedge baud_clk);
      chk("f0F_low_no_active", 32'(active_total - snap_act), 32'd0);
      chk("f0F_low_no_valid", 32'(rise_total - snap), 32'd0);
      drive_bit(1'b1);
      snap = rise_total;
      pbit = (^8'h5A) ^ ODD;
      push(8'h5A, pbit, 1'b1);
      send_frame(8'h5A, pbit, 1'b1);
      expect_frame("f5A_rearm", snap);
      consume("f5A");

      // overrun: two frames without consuming
      snap = rise_total;
      push(8'h11, (^8'h11) ^ ODD, 1'b1);
      send_frame(8'h11, (^8'h11) ^ ODD, 1'b1);
      send_frame(8'h22, (^8'h22) ^ ODD, 1'b1);
      expect_frame("ovr", snap);
      chk("ovr_data_kept", 32'(rif.rx_data), 32'h11);
      chk("ovr_valid", 32'(rif.rx_valid), 32'd1);
      chk("ovr_flag", 32'(rif.overrun_err), 32'd1);
      consume("ovr");
      chk("ovr_sticky", 32'(rif.overrun_err), 32'd1);
      rif.err_clr = 1'b1;
      @(negedge baud_clk);
      rif.err_clr = 1'b0;
      chk("ovr_cleared", 32'(rif.overrun_err), 32'd0);

      // reset during data bit 4
      snap = rise_total;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      data_tx = 1'b0;
      repeat (OS / 2) @(negedge baud_clk);
      reset   = 1'b1;
      data_tx = 1'b1;
      repeat (2) @(negedge baud_clk);
      chk("rmid_active", 32'(active_flag), 32'd0);
      reset = 1'b0;
      repeat (20) @(negedge baud_clk);
      chk("rmid_no_valid", 32'(rise_total - snap), 32'd0);
      snap = rise_total;
      push(8'h3C, (^8'h3C) ^ ODD, 1'b1);
      send_frame(8'h3C, (^8'h3C) ^ ODD, 1'b1);
      expect_frame("f3C", snap);
      consume("f3C");

      // back-to-back with rx_ready held
      rif.rx_ready = 1'b1;
      snap = rise_total;
      push(8'hC5, (^8'hC5) ^ ODD, 1'b1);
      push(8'h3A, (^8'h3A) ^ ODD, 1'b1);
      send_frame(8'hC5, (^8'hC5) ^ ODD, 1'b1);
      expect_frame("b2b_1", snap);
      send_frame(8'h3A, (^8'h3A) ^ ODD, 1'b1);
      expect_frame("b2b_2", snap + 1);
      chk("b2b_no_ovr", 32'(rif.overrun_err), 32'd0);
      chk("b2b_valid_drained", 32'(rif.rx_valid), 32'd0);
      rif.rx_ready = 1'b0;
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
